// File: rtl/ram_dp_init_if.sv
// ram_dp_init_if: write/read bus between the bus-side writer, the LCD controller and ram_dp_init.
// Revision: 1.0 - initial release.
`default_nettype none

interface ram_dp_init_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              clr;
    logic              wr;
    logic [ADDR_W-1:0] addr_wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              init_done;
    logic              rd_seen;

    modport master (
        output clr, wr, addr_wr, din, rd, addr_rd,
        input  dout, dout_valid, busy, init_done, rd_seen
    );

    modport slave (
        input  clr, wr, addr_wr, din, rd, addr_rd,
        output dout, dout_valid, busy, init_done, rd_seen
    );
endinterface

`default_nettype wire

// File: rtl/ram_dp_init.sv
// ram_dp_init: simple dual-port RAM with a clear sequencer that fills every word with INIT_VAL.
// Optional macro RAM_DP_OUT_REG_EN adds an output pipeline stage (2-cycle read latency).
// Revision: 1.0 - initial release.
`default_nettype none

module ram_dp_init #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  wire logic       clk2_i,
    input  wire logic       rst_i,
    ram_dp_init_if.slave    bus
);
    localparam logic [0:0]        ST_CLEAR = 1'b0;
    localparam logic [0:0]        ST_IDLE  = 1'b1;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              rd_seen_q;
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;

    logic              idle;
    logic              rd_acc;
    logic              clr_start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idle      = (state_q == ST_IDLE);
    assign rd_acc    = idle & bus.rd;
    assign clr_start = idle & bus.clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_CLEAR) begin
            if (bus.clr) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.clr) begin
            state_d     = ST_CLEAR;
            cnt_d       = '0;
            init_done_d = 1'b0;
        end
    end

    // The clear pass owns the write port; bus writes only land while idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.addr_wr;
        mem_wdata = bus.din;
        if (rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VAL;
            end else begin
                mem_we = bus.wr;
            end
        end
    end

    always_ff @(posedge clk2_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Nonblocking read of the same array gives read-first behaviour on a collision.
    always_ff @(posedge clk2_i) begin
        if (!rst_i) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_seen_q   <= 1'b0;
            dout_q      <= '0;
            dv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            dv_q        <= rd_acc;
            if (rd_acc) begin
                dout_q    <= mem_q[bus.addr_rd];
                rd_seen_q <= 1'b1;
            end
        end
    end

`ifdef RAM_DP_OUT_REG_EN
    logic [DATA_W-1:0] dout2_q;
    logic              dv2_q;

    // A starting clear drops whatever sits in the first stage.
    always_ff @(posedge clk2_i) begin
        if (!rst_i) begin
            dout2_q <= '0;
            dv2_q   <= 1'b0;
        end else begin
            dv2_q <= dv_q & ~clr_start;
            if (dv_q & ~clr_start) begin
                dout2_q <= dout_q;
            end
        end
    end

    assign bus.dout       = dout2_q;
    assign bus.dout_valid = dv2_q;
`else
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
`endif

    assign bus.busy      = (state_q == ST_CLEAR);
    assign bus.init_done = init_done_q;
    assign bus.rd_seen   = rd_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_init.sv
// tb_ram_dp_init: directed table, corner sequences and randomized traffic against a behavioural model.
`default_nettype none

module tb_ram_dp_init;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] INIT = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    ram_dp_init_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    ram_dp_init #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT)) dut (
        .clk2_i (clk),
        .rst_i  (rst_n),
        .bus    (ifc.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory array plus a "words still to clear" view of the sequencer.
    logic [DW-1:0] mm [DEPTH];
    bit            m_busy = 1'b1;
    int            m_idx = 0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;
    bit            m_v1 = 1'b0, m_v2 = 1'b0, m_init = 1'b0, m_seen = 1'b0;

    task automatic model_edge();
        logic [DW-1:0] od1;
        bit ov1, start;
        od1 = m_d1; ov1 = m_v1; start = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b1; m_idx = 0; m_d1 = '0; m_v1 = 1'b0; m_init = 1'b0; m_seen = 1'b0;
        end else if (m_busy) begin
            mm[m_idx] = INIT;
            m_v1 = 1'b0;
            if (ifc.clr) m_idx = 0;
            else if (m_idx == DEPTH - 1) begin m_busy = 1'b0; m_init = 1'b1; end
            else m_idx++;
        end else begin
            start = ifc.clr;
            m_v1 = ifc.rd;
            if (ifc.rd) begin m_d1 = mm[ifc.addr_rd]; m_seen = 1'b1; end
            if (ifc.wr) mm[ifc.addr_wr] = ifc.din;
            if (ifc.clr) begin m_busy = 1'b1; m_idx = 0; m_init = 1'b0; end
        end
        if (!rst_n) begin m_d2 = '0; m_v2 = 1'b0; end
        else begin
            m_v2 = ov1 && !start;
            if (ov1 && !start) m_d2 = od1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        logic [DW+3:0] exp_v, got_v;
        model_edge();
        @(posedge clk);
        #1;
`ifdef RAM_DP_OUT_REG_EN
        exp_v = {m_d2, m_v2, m_busy, m_init, m_seen};
`else
        exp_v = {m_d1, m_v1, m_busy, m_init, m_seen};
`endif
        got_v = {ifc.dout, ifc.dout_valid, ifc.busy, ifc.init_done, ifc.rd_seen};
        chk("model{dout,dv,busy,init,seen}", 32'(got_v), 32'(exp_v));
    endtask

    task automatic idle_in();
        ifc.clr = 1'b0; ifc.wr = 1'b0; ifc.rd = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_in(); ifc.wr = 1'b1; ifc.addr_wr = a; ifc.din = d;
        step(); idle_in();
    endtask

    // Counts edges until busy falls; bounded so a stuck sequencer still reaches the summary.
    task automatic busy_len(input string name);
        int n;
        n = 0;
        do begin
            step(); n++;
        end while (ifc.busy && n < 2000);
        chk(name, 32'(n), 32'd256);
        chk({name, "_init_done"}, 32'(ifc.init_done), 32'd1);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] din;
        logic          rd;
        logic [AW-1:0] ra;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 8'h12, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h12, 1'b1, 16'hBEEF};
        tbl[2] = '{1'b1, 8'h40, 16'h1111, 1'b0, 8'h00, 1'b0, 16'hBEEF};
        tbl[3] = '{1'b1, 8'h40, 16'h2222, 1'b1, 8'h40, 1'b1, 16'h1111};
        tbl[4] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h40, 1'b1, 16'h2222};
        tbl[5] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h7F, 1'b1, 16'h0000};
        tbl[6] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1, 16'h0000};
        tbl[7] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'h0000};
        tbl[8] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000};
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;

        idle_in(); ifc.addr_wr = '0; ifc.addr_rd = '0; ifc.din = '0;

        // Reset held three cycles, then a full clear pass.
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_dout", 32'(ifc.dout), 32'd0);
        chk("rst_dv", 32'(ifc.dout_valid), 32'd0);
        chk("rst_init_done", 32'(ifc.init_done), 32'd0);
        chk("rst_rd_seen", 32'(ifc.rd_seen), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b1;
        busy_len("reset_busy_len");

`ifndef RAM_DP_OUT_REG_EN
        for (int i = 0; i < 9; i++) begin
            ifc.wr = tbl[i].wr; ifc.addr_wr = tbl[i].wa; ifc.din = tbl[i].din;
            ifc.rd = tbl[i].rd; ifc.addr_rd = tbl[i].ra;
            step();
            chk($sformatf("tbl%0d_dv", i), 32'(ifc.dout_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_dout", i), 32'(ifc.dout), 32'(tbl[i].ed));
        end
        chk("tbl_rd_seen", 32'(ifc.rd_seen), 32'd1);
        idle_in();
`endif

        // Clear request: rd/wr during the pass are ignored.
        for (int i = 0; i < 16; i++) do_write(AW'(i), 16'hA5A5);
        chk("pre_clr_init_done", 32'(ifc.init_done), 32'd1);
        ifc.clr = 1'b1; step(); ifc.clr = 1'b0;
        chk("clr_busy", 32'(ifc.busy), 32'd1);
        chk("clr_init_done", 32'(ifc.init_done), 32'd0);
        ifc.wr = 1'b1; ifc.addr_wr = 8'h05; ifc.din = 16'h5555;
        ifc.rd = 1'b1; ifc.addr_rd = 8'h05;
        step();
        chk("clr_dv_blocked", 32'(ifc.dout_valid), 32'd0);
        begin
            int n;
            n = 1;
            do begin step(); n++; end while (ifc.busy && n < 2000);
            chk("clr_busy_len", 32'(n), 32'd256);
            chk("clr_init_done_again", 32'(ifc.init_done), 32'd1);
        end
        idle_in(); ifc.rd = 1'b1; ifc.addr_rd = 8'h05; step(); idle_in();
`ifndef RAM_DP_OUT_REG_EN
        chk("clr_lost_write", 32'(ifc.dout), 32'd0);
        chk("clr_lost_write_dv", 32'(ifc.dout_valid), 32'd1);
`endif
        step();

        // Reset in the middle of a clear restarts the full pass.
        for (int i = 0; i < 8; i++) do_write(AW'(i * 37), 16'h7E57);
        ifc.clr = 1'b1; step(); ifc.clr = 1'b0;
        repeat (100) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        busy_len("midclr_busy_len");
        for (int i = 0; i < DEPTH; i++) begin
            ifc.rd = 1'b1; ifc.addr_rd = AW'(i); step();
`ifndef RAM_DP_OUT_REG_EN
            if (ifc.dout !== 16'h0000) chk($sformatf("midclr_word%0d", i), 32'(ifc.dout), 32'd0);
`endif
        end
        idle_in(); step(); step();

`ifdef RAM_DP_OUT_REG_EN
        for (int i = 1; i <= 3; i++) do_write(AW'(i), DW'(i));
        for (int k = 0; k < 5; k++) begin
            ifc.rd = (k < 3); ifc.addr_rd = AW'(k + 1);
            step();
            chk($sformatf("pipe%0d_dv", k), 32'(ifc.dout_valid), 32'(k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk($sformatf("pipe%0d_dout", k), 32'(ifc.dout), 32'(k));
        end
        idle_in();
`endif

        // Randomized traffic; narrow address window half the time to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            rst_n = ($urandom_range(0, 999) != 0);
            ifc.clr = ($urandom_range(0, 299) == 0);
            ifc.wr = $urandom_range(0, 1) == 1;
            ifc.rd = $urandom_range(0, 1) == 1;
            ifc.addr_wr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ifc.addr_rd = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ifc.din = DW'($urandom);
            step();
        end
        rst_n = 1'b1; idle_in(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
